muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 src_a  input  WIDTH  multiplicand/dividend; captured with start.
REQ-007 src_b  input  WIDTH  multiplier/divisor; captured with start.
REQ-008 busy  output  1  high in CALC and FIXUP.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 hi  output  WIDTH  product high word / remainder.
REQ-011 lo  output  WIDTH  product low word / quotient.
REQ-012 div_by_zero  output  1  high with done when DIV/DIVU had src_b==0.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIXUP and DONE.
REQ-014 IDLE + start: capture op/src_a/src_b and go to CALC; divide with src_b==0 goes to DONE instead.
REQ-015 Signed ops: CALC operates on operand magnitudes; record sign flags at capture.
REQ-016 CALC: exactly WIDTH cycles, one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; 6-bit iteration counter 0..WIDTH-1.
REQ-017 After the last CALC step, go to FIXUP for one cycle.
REQ-018 FIXUP, MULT: negate the 64-bit product when the operand signs differ.
REQ-019 FIXUP, DIV: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
REQ-020 FIXUP, unsigned ops: pass the result unchanged.
REQ-021 hi/lo SHALL update on entry to DONE and hold until the next DONE entry or reset.
REQ-022 DONE lasts one cycle (done=1), then IDLE.
REQ-023 Latency: start sampled at cycle 0 gives done at cycle WIDTH+2 (34).
REQ-024 Divide-by-zero: done at cycle 1, hi=src_a, lo=all ones, div_by_zero=1.
REQ-025 div_by_zero SHALL be 0 in every cycle except a divide-by-zero DONE.
REQ-026 start in CALC/FIXUP/DONE SHALL be ignored; no queueing; changes to src_a/src_b/op after capture SHALL have no effect.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no error flag.
REQ-028 Intermediate accumulators SHALL be WIDTH+1 bits for the divide subtract; the product register SHALL be 2*WIDTH bits.

Reset
REQ-029 reset=1 at a rising edge in any state: next state IDLE.
REQ-030 After reset: busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
REQ-031 Reset mid-CALC SHALL discard the operation; no done is produced.
REQ-032 reset SHALL take priority over start in the same cycle.

Structure
REQ-033 Package muldiv_pkg SHALL hold the op encoding enum, the state enum and the constant ITER=WIDTH.
REQ-034 One sub-module, muldiv_step: combinational WIDTH+1-bit add/subtract for the per-iteration step, instantiated once.
REQ-035 State, counter, operand and result registers SHALL reside in muldiv_sequencer.

Verification
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF -> cycle 34: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy=1 cycles 1-33.
REQ-037 MULT 0xFFFFFFFD(-3)*0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-038 DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-039 DIVU 0x64/0 -> cycle 1: done=1, div_by_zero=1, hi=0x64, lo=0xFFFFFFFF.
REQ-040 Second start at cycle 5 with other operands -> ignored, first result at cycle 34, single done pulse.
REQ-041 reset at cycle 10 of CALC -> cycle 11: busy=0, hi=lo=0, no done; a new start then completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide sequencer
package muldiv_pkg;
   localparam int DATA_W = 32;
   localparam int ITER   = DATA_W;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10,
      ST_DONE  = 2'b11
   } state_e;
endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between a requester and the sequencer
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DATA_W
) ();
   logic             start;
   op_e              op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, src_a, src_b,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, src_a, src_b,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one-iteration WIDTH+1-bit adder/subtractor
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] i_a,
   input  logic [WIDTH:0] i_b,
   input  logic           i_sub,
   output logic [WIDTH:0] o_res
);
   assign o_res = i_sub ? (i_a - i_b) : (i_a + i_b);
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative 32-bit signed/unsigned multiply and divide
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);
   state_e             r_state, w_next;
   logic [5:0]         r_cnt;
   logic               r_is_div;
   logic               r_sign_a, r_sign_b;
   logic [WIDTH-1:0]   r_opb;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_dbz;

   logic               w_busy, w_done;
   logic               w_req_div, w_req_signed, w_req_dbz;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [WIDTH:0]     w_step_a, w_step_b, w_step_res;
   logic               w_step_sub;
   logic [2*WIDTH-1:0] w_prod_next, w_prod_neg;
   logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

   // Decode the incoming request; signed ops work on operand magnitudes
   assign w_req_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign w_req_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign w_req_dbz    = w_req_div && (bus.src_b == '0);
   assign w_mag_a      = (w_req_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
   assign w_mag_b      = (w_req_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

   // Divide keeps {remainder, quotient} in r_prod; the shifted-in remainder is r_prod[2W-1:W-1]
   always_comb begin
      w_step_sub = r_is_div;
      w_step_b   = {1'b0, r_opb};
      w_step_a   = r_is_div ? r_prod[2*WIDTH-1:WIDTH-1] : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
      if (r_is_div) begin
         w_prod_next = w_step_res[WIDTH] ? {r_prod[2*WIDTH-2:0], 1'b0}
                                         : {w_step_res[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
      end else begin
         w_prod_next = r_prod[0] ? {w_step_res, r_prod[WIDTH-1:1]}
                                 : {1'b0, r_prod[2*WIDTH-1:1]};
      end
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_a   (w_step_a),
      .i_b   (w_step_b),
      .i_sub (w_step_sub),
      .o_res (w_step_res)
   );

   // Sign correction; sign flags are zero for unsigned ops so those pass through
   always_comb begin
      w_prod_neg = -r_prod;
      if (r_is_div) begin
         w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
         w_fix_hi = r_sign_a ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
      end else begin
         w_fix_lo = (r_sign_a ^ r_sign_b) ? w_prod_neg[WIDTH-1:0] : r_prod[WIDTH-1:0];
         w_fix_hi = (r_sign_a ^ r_sign_b) ? w_prod_neg[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and status outputs
   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_IDLE:  if (bus.start) w_next = w_req_dbz ? ST_DONE : ST_CALC;
         ST_CALC: begin
            w_busy = 1'b1;
            if (r_cnt == 6'(ITER-1)) w_next = ST_FIXUP;
         end
         ST_FIXUP: begin
            w_busy = 1'b1;
            w_next = ST_DONE;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_opb    <= '0;
         r_prod   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dbz    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.start) begin
               r_cnt    <= '0;
               r_is_div <= w_req_div;
               r_sign_a <= w_req_signed && bus.src_a[WIDTH-1];
               r_sign_b <= w_req_signed && bus.src_b[WIDTH-1];
               r_opb    <= w_mag_b;
               r_prod   <= {{WIDTH{1'b0}}, w_mag_a};
               r_dbz    <= w_req_dbz;
               if (w_req_dbz) begin
                  r_hi <= bus.src_a;
                  r_lo <= '1;
               end
            end
            ST_CALC: begin
               r_prod <= w_prod_next;
               r_cnt  <= (r_cnt == 6'(ITER-1)) ? 6'd0 : r_cnt + 6'd1;
            end
            ST_FIXUP: begin
               r_hi <= w_fix_hi;
               r_lo <= w_fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.div_by_zero = w_done & r_dbz;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_vec  = 0;
   int   n_miss = 0;

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Reference arithmetic straight from the operation definitions
   function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      dbz = 1'b0;
      hi  = '0;
      lo  = '0;
      case (op)
         2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               dbz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
            end else if (op == 2'b10) begin
               q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
            end else begin
               lo = a / b; hi = a % b;
            end
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model timeline: which cycle finishes the accepted op and what result it carries
   int          cyc = 0, start_cyc = 0, done_cyc = 0;
   bit          active = 1'b0, chk_en = 1'b0;
   logic [31:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;
   logic        pend_dbz = 1'b0;

   // Advance the model on every rising edge using the inputs the DUT sampled
   always @(posedge clk) begin
      int prev;
      prev = cyc;
      cyc  = cyc + 1;
      if (reset) begin
         active = 1'b0; exp_hi = '0; exp_lo = '0;
      end else if (bus.start && !(active && prev <= done_cyc)) begin
         ref_model(bus.op, bus.src_a, bus.src_b, pend_hi, pend_lo, pend_dbz);
         active    = 1'b1;
         start_cyc = prev;
         done_cyc  = prev + (pend_dbz ? 1 : 34);
      end
      if (active && !reset && cyc == done_cyc) begin
         exp_hi = pend_hi; exp_lo = pend_lo;
      end
   end

   // Compare every DUT output against the model on each falling edge
   always @(negedge clk) begin
      logic e_busy, e_done;
      if (chk_en) begin
         e_busy = active && cyc > start_cyc && cyc < done_cyc;
         e_done = active && cyc == done_cyc;
         chk("busy", 64'(bus.busy), 64'(e_busy));
         chk("done", 64'(bus.done), 64'(e_done));
         chk("div_by_zero", 64'(bus.div_by_zero), 64'(e_done && pend_dbz));
         chk("hi", 64'(bus.hi), 64'(exp_hi));
         chk("lo", 64'(bus.lo), 64'(exp_lo));
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 255));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input int restart_at,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz, output int lat);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op_e'(op); bus.src_a = a; bus.src_b = b;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.src_a = $urandom;
         bus.src_b = $urandom;
         bus.op    = op_e'(2'($urandom_range(0, 3)));
         bus.start = (lat == restart_at) || (noise && ($urandom_range(0, 3) == 0));
      end while (!bus.done && lat < 40);
      hi = bus.hi; lo = bus.lo; dbz = bus.div_by_zero;
      bus.start = 1'b0;
      if (!bus.done) begin
         n_vec++; n_miss++;
         $display("FAIL done_timeout: got no done within %0d cycles expected done", lat);
      end
   endtask

   logic [31:0] h, l;
   logic        d;
   int          lat;

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.op = OP_MULT; bus.src_a = '0; bus.src_b = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      reset = 1'b0;

      ref_model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, d);
      chk("model_multu", {h, l}, 64'hFFFF_FFFE_0000_0001);
      ref_model(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, h, l, d);
      chk("model_mult", {h, l}, 64'hFFFF_FFFF_FFFF_FFEB);
      ref_model(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, h, l, d);
      chk("model_div", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
      ref_model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l, d);
      chk("model_div_ovf", {h, l, 31'b0, d}, {64'h0000_0000_8000_0000, 32'h0});
      ref_model(2'b11, 32'h64, 32'h0, h, l, d);
      chk("model_dbz", {h, l, 31'b0, d}, {64'h0000_0064_FFFF_FFFF, 32'h1});

      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, h, l, d, lat);
      chk("multu_lat", 64'(lat), 64'd34);
      chk("multu_res", {h, l}, 64'hFFFF_FFFE_0000_0001);
      do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 0, h, l, d, lat);
      chk("mult_res", {h, l}, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 0, h, l, d, lat);
      chk("div_res", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(2'b11, 32'd100, 32'd7, 1'b0, 0, h, l, d, lat);
      chk("divu_res", {h, l}, {32'd2, 32'd14});
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, h, l, d, lat);
      chk("div_ovf_res", {h, l, 31'b0, d}, {64'h0000_0000_8000_0000, 32'h0});
      do_op(2'b11, 32'h64, 32'h0, 1'b0, 0, h, l, d, lat);
      chk("dbz_lat", 64'(lat), 64'd1);
      chk("dbz_res", {h, l, 31'b0, d}, {64'h0000_0064_FFFF_FFFF, 32'h1});

      // Reset ten cycles into a calculation discards it
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3;
      repeat (10) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      // Reset wins over a simultaneous start
      reset = 1'b1; bus.start = 1'b1; bus.op = OP_MULTU;
      @(negedge clk);
      reset = 1'b0; bus.start = 1'b0;
      chk("rst_vs_start_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk("rst_vs_start_busy2", 64'(bus.busy), 64'd0);

      do_op(2'b11, 32'd100, 32'd7, 1'b0, 0, h, l, d, lat);
      chk("post_rst_divu", {h, l}, {32'd2, 32'd14});

      for (int i = 0; i < 70; i++) begin
         do_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b1, 0, h, l, d, lat);
      end

      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
